// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch and data ports onto a 16-bit byte-addressed memory,
// running byte stores as read-modify-write. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_access_ctrl #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  output logic          busy
);

  localparam int unsigned BW = DW / 2;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ACK} state_t;

  state_t        state;
  state_t        state_next;
  logic          sel_d;
  logic          we_q;
  logic          byte_q;
  logic          lsb_q;
  logic [BW-1:0] wbyte_q;
  logic          any_req_c;
  logic          grant_d_c;
  logic [AW-1:0] addr_c;
  logic [BW-1:0] lane_c;
  logic [DW-1:0] merged_c;
  logic [DW-1:0] load_c;
  logic          mem_write_next;
  logic          mem_read_next;
  logic          busy_next;
  logic          if_ack_next;
  logic          d_ack_next;

  assign any_req_c = d_req | if_req;

`ifdef MEM_ARB_RR_EN
  // Last-grant flag: 1 = data port granted most recently; resets to fetch so data wins the first tie.
  logic last_d;

  assign grant_d_c = d_req & (~if_req | ~last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (state == S_IDLE && any_req_c) begin
      last_d <= grant_d_c;
    end
  end
`else
  assign grant_d_c = d_req;
`endif

  assign addr_c   = grant_d_c ? d_addr : if_addr;
  assign lane_c   = lsb_q ? mem_data_out[DW-1:BW] : mem_data_out[BW-1:0];
  assign merged_c = lsb_q ? {wbyte_q, mem_data_out[BW-1:0]} : {mem_data_out[DW-1:BW], wbyte_q};
  assign load_c   = byte_q ? {BW'(0), lane_c} : mem_data_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus Moore outputs decoded from the state being entered, so they register in step.
  always_comb begin
    state_next     = state;
    mem_write_next = 1'b0;
    mem_read_next  = 1'b0;
    busy_next      = 1'b0;
    if_ack_next    = 1'b0;
    d_ack_next     = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_req_c) begin
          state_next = (grant_d_c && d_we && !d_byte) ? S_WR : S_RD;
        end
      end
      S_RD:    state_next = S_WAIT;
      S_WAIT:  state_next = we_q ? S_WR : S_ACK;
      S_WR:    state_next = S_ACK;
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Memory strobe convention: {mem_write,mem_read} = 2'b10 reads, 2'b01 writes.
    mem_write_next = (state_next == S_RD);
    mem_read_next  = (state_next == S_WR);
    busy_next      = (state_next != S_IDLE);
    d_ack_next     = (state_next == S_ACK) && sel_d;
    if_ack_next    = (state_next == S_ACK) && !sel_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      busy        <= 1'b0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      sel_d       <= 1'b0;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      lsb_q       <= 1'b0;
      wbyte_q     <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
    end else begin
      mem_write <= mem_write_next;
      mem_read  <= mem_read_next;
      busy      <= busy_next;
      if_ack    <= if_ack_next;
      d_ack     <= d_ack_next;
      if (state == S_IDLE && any_req_c) begin
        sel_d       <= grant_d_c;
        we_q        <= grant_d_c & d_we;
        byte_q      <= grant_d_c & d_byte;
        lsb_q       <= grant_d_c & addr_c[0];
        wbyte_q     <= d_wdata[BW-1:0];
        mem_address <= {addr_c[AW-1:1], 1'b0};
        if (grant_d_c && d_we && !d_byte) begin
          mem_data_in <= d_wdata;
        end
      end
      // Read word arrives during WAIT: merge for byte store, else deliver it for the ACK cycle.
      if (state == S_WAIT) begin
        if (we_q) begin
          mem_data_in <= merged_c;
        end else if (sel_d) begin
          d_rdata <= load_c;
        end else begin
          if_rdata <= mem_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized traffic
// against a word-array memory model and a transaction-level reference.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Physical memory (written only by the DUT or the backdoor) and the reference image.
  logic [15:0] phys [0:255];
  logic [15:0] ref_mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'h0;
  logic [15:0] bd_data = 16'h0;

  always @(posedge clk) begin
    if (bd_we) phys[bd_idx] <= bd_data;
    if (mem_write && !mem_read) mem_data_out <= phys[mem_address[8:1]];
    if (!mem_write && mem_read) phys[mem_address[8:1]] <= mem_data_in;
  end

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      checks++;
      if ({mem_write, mem_read} === 2'b11 || mem_address[0] !== 1'b0) begin
        errors++;
        $display("FAIL strobe_legal: strobes=%b addr=%h, want no 2'b11 and even address",
                 {mem_write, mem_read}, mem_address);
      end
    end
  end

  int          lat;
  int          other_ack;
  logic [15:0] got;
  logic [1:0]  strb [0:15];
  logic [15:0] addr_tr [0:15];

  task automatic poke(input int idx, input logic [15:0] data);
    bd_we = 1'b1; bd_idx = 8'(idx); bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 256; i++) poke(i, 16'($urandom));
    poke(0, 16'h2BCD);
    poke(3, 16'h1234);
    poke(8'h21, ~ref_mem[8'h20]);
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_data(input logic we, input logic byt, input logic [15:0] addr,
                          input logic [15:0] wdata);
    int n;
    wait_idle();
    d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wdata;
    lat = -1; other_ack = 0; n = 0;
    while (n < 15) begin
      @(negedge clk);
      n++;
      strb[4'(n)] = {mem_write, mem_read};
      addr_tr[4'(n)] = mem_address;
      if (if_ack) other_ack++;
      if (d_ack) begin
        lat = n;
        break;
      end
    end
    d_req = 1'b0;
    got = d_rdata;
  endtask

  task automatic run_fetch(input logic [15:0] addr);
    int n;
    wait_idle();
    if_req = 1'b1; if_addr = addr;
    lat = -1; other_ack = 0; n = 0;
    while (n < 15) begin
      @(negedge clk);
      n++;
      strb[4'(n)] = {mem_write, mem_read};
      addr_tr[4'(n)] = mem_address;
      if (d_ack) other_ack++;
      if (if_ack) begin
        lat = n;
        break;
      end
    end
    if_req = 1'b0;
    got = if_rdata;
  endtask

  function automatic logic [15:0] model_load(input logic [15:0] addr, input logic byt);
    logic [15:0] w;
    w = ref_mem[addr[8:1]];
    if (!byt) return w;
    return addr[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  function automatic int model_lat(input logic fetch, input logic we, input logic byt);
    if (fetch || !we) return 3;
    return byt ? 4 : 2;
  endfunction

  task automatic model_store(input logic byt, input logic [15:0] addr, input logic [15:0] wdata);
    if (!byt) ref_mem[addr[8:1]] = wdata;
    else if (addr[0]) ref_mem[addr[8:1]][15:8] = wdata[7:0];
    else ref_mem[addr[8:1]][7:0] = wdata[7:0];
  endtask

  task automatic test_reset;
    int acks;
    checks++;
    if ({mem_write, mem_read, busy, if_ack, d_ack} !== 5'b0 || mem_address !== 16'h0 ||
        mem_data_in !== 16'h0 || if_rdata !== 16'h0 || d_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: strb=%b busy=%b acks=%b%b addr=%h wd=%h ird=%h drd=%h, want all 0",
               {mem_write, mem_read}, busy, if_ack, d_ack, mem_address, mem_data_in, if_rdata, d_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    run_data(1'b0, 1'b0, 16'h0006, 16'h0);
    checks++;
    if (got !== model_load(16'h0006, 1'b0) || lat != 3) begin
      errors++; $display("FAIL preload: rdata %h lat %0d want %h lat 3", got, lat, model_load(16'h0006, 1'b0));
    end
    wait_idle();
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 16'h0003; d_wdata = 16'h00AA;
    @(negedge clk);
    checks++;
    if ({mem_write, mem_read} !== 2'b10) begin
      errors++; $display("FAIL rd_before_reset: strobes %b want 10", {mem_write, mem_read});
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_write, mem_read} !== 2'b00 || busy !== 1'b0 || d_ack !== 1'b0) begin
      errors++; $display("FAIL reset_async: strobes %b busy %b ack %b want 00 0 0", {mem_write, mem_read}, busy, d_ack);
    end
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_ack || if_ack) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL reset_no_ack: got %0d acks want 0", acks); end
    checks++;
    if (busy !== 1'b0 || mem_address !== 16'h0 || mem_data_in !== 16'h0 || d_rdata !== 16'h0 || if_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_cleared: busy %b addr %h wd %h drd %h ird %h want all 0",
                         busy, mem_address, mem_data_in, d_rdata, if_rdata);
    end
    checks++;
    if (phys[1] !== ref_mem[1]) begin
      errors++; $display("FAIL reset_no_write: mem %h want %h", phys[1], ref_mem[1]);
    end
  endtask

  task automatic test_word_load;
    run_data(1'b0, 1'b0, 16'h0001, 16'h0);
    checks++;
    if (lat != 3 || got !== 16'h2BCD || other_ack != 0) begin
      errors++; $display("FAIL word_load: lat %0d rdata %h other %0d want 3 2bcd 0", lat, got, other_ack);
    end
    checks++;
    if (strb[1] !== 2'b10 || addr_tr[1] !== 16'h0000 || strb[2] !== 2'b00 || strb[3] !== 2'b00) begin
      errors++; $display("FAIL word_load_strobes: %b %b %b addr %h want 10 00 00 0000",
                         strb[1], strb[2], strb[3], addr_tr[1]);
    end
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b0 || d_rdata !== 16'h2BCD) begin
      errors++; $display("FAIL ack_pulse: ack %b rdata %h want 0 2bcd", d_ack, d_rdata);
    end
  endtask

  task automatic test_byte_load;
    run_data(1'b0, 1'b1, 16'h0001, 16'h0);
    checks++;
    if (lat != 3 || got !== 16'h002B) begin
      errors++; $display("FAIL byte_load_odd: lat %0d rdata %h want 3 002b", lat, got);
    end
    run_data(1'b0, 1'b1, 16'h0000, 16'h0);
    checks++;
    if (lat != 3 || got !== 16'h00CD) begin
      errors++; $display("FAIL byte_load_even: lat %0d rdata %h want 3 00cd", lat, got);
    end
  endtask

  task automatic test_store;
    run_data(1'b1, 1'b1, 16'h0001, 16'h0077);
    model_store(1'b1, 16'h0001, 16'h0077);
    checks++;
    if (lat != 4 || strb[1] !== 2'b10 || strb[2] !== 2'b00 || strb[3] !== 2'b01) begin
      errors++; $display("FAIL byte_store_seq: lat %0d strobes %b %b %b want 4 10 00 01", lat, strb[1], strb[2], strb[3]);
    end
    checks++;
    if (phys[0] !== 16'h77CD) begin errors++; $display("FAIL byte_store_mem: %h want 77cd", phys[0]); end
    run_data(1'b0, 1'b0, 16'h0000, 16'h0);
    checks++;
    if (got !== 16'h77CD) begin errors++; $display("FAIL byte_store_readback: %h want 77cd", got); end
    run_data(1'b1, 1'b0, 16'h0005, 16'hA5A5);
    model_store(1'b0, 16'h0005, 16'hA5A5);
    checks++;
    if (lat != 2 || strb[1] !== 2'b01 || addr_tr[1] !== 16'h0004 || phys[2] !== 16'hA5A5) begin
      errors++; $display("FAIL word_store: lat %0d strobe %b addr %h mem %h want 2 01 0004 a5a5",
                         lat, strb[1], addr_tr[1], phys[2]);
    end
  endtask

  task automatic test_random;
    logic        fetch, we, byt;
    logic [15:0] addr, wdata, exp;
    for (int i = 0; i < 60; i++) begin
      fetch = 1'($urandom_range(0, 2) == 0);
      we    = 1'($urandom);
      byt   = 1'($urandom);
      addr  = 16'($urandom_range(0, 511));
      wdata = 16'($urandom);
      if (fetch) begin
        exp = model_load(addr, 1'b0);
        run_fetch(addr);
        checks++;
        if (lat != model_lat(1'b1, 1'b0, 1'b0) || got !== exp || other_ack != 0) begin
          errors++; $display("FAIL rand_fetch[%0d]: addr %h lat %0d rdata %h want lat 3 %h", i, addr, lat, got, exp);
        end
      end else if (!we) begin
        exp = model_load(addr, byt);
        run_data(1'b0, byt, addr, wdata);
        checks++;
        if (lat != model_lat(1'b0, 1'b0, byt) || got !== exp || other_ack != 0) begin
          errors++; $display("FAIL rand_load[%0d]: addr %h byte %b lat %0d rdata %h want lat 3 %h", i, addr, byt, lat, got, exp);
        end
      end else begin
        model_store(byt, addr, wdata);
        run_data(1'b1, byt, addr, wdata);
        checks++;
        if (lat != model_lat(1'b0, 1'b1, byt) || phys[addr[8:1]] !== ref_mem[addr[8:1]]) begin
          errors++; $display("FAIL rand_store[%0d]: addr %h byte %b lat %0d mem %h want lat %0d %h",
                             i, addr, byt, lat, phys[addr[8:1]], model_lat(1'b0, 1'b1, byt), ref_mem[addr[8:1]]);
        end
      end
    end
  endtask

  task automatic test_arbitration;
    int          d1, d2, fc, nd, n, extra, exp_d2, exp_f;
    logic [15:0] d_got, f_got;
`ifdef MEM_ARB_RR_EN
    exp_f = 6; exp_d2 = 10;
`else
    exp_f = 10; exp_d2 = 6;
`endif
    wait_idle();
    if_req = 1'b1; if_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b0; d_addr = 16'h0020; d_wdata = 16'hBEEF;
    model_store(1'b0, 16'h0020, 16'hBEEF);
    d1 = -1; d2 = -1; fc = -1; nd = 0; n = 0; extra = 0;
    d_got = 16'h0; f_got = 16'h0;
    while (n < 30 && (nd < 2 || fc < 0)) begin
      @(negedge clk);
      n++;
      if (d_ack) begin
        if (nd == 0) d1 = n;
        else if (nd == 1) begin d2 = n; d_got = d_rdata; end
        else extra++;
        nd++;
        d_req = 1'b0;
      end
      if (if_ack) begin
        if (fc < 0) begin fc = n; f_got = if_rdata; end
        else extra++;
        if_req = 1'b0;
      end
      if (n == 3) begin d_req = 1'b1; d_we = 1'b0; end
    end
    checks++;
    if (d1 != 2) begin errors++; $display("FAIL arb_first: data ack cycle %0d want 2", d1); end
    checks++;
    if (fc != exp_f || d2 != exp_d2) begin
      errors++; $display("FAIL arb_order: fetch ack %0d data ack %0d want %0d %0d", fc, d2, exp_f, exp_d2);
    end
    checks++;
    if (f_got !== ref_mem[8] || d_got !== 16'hBEEF || extra != 0) begin
      errors++; $display("FAIL arb_data: fetch %h load %h extra %0d want %h beef 0", f_got, d_got, extra, ref_mem[8]);
    end
  endtask

  task automatic test_back_to_back;
    int          acks, c1, c2, dacks;
    logic [15:0] g1, g2;
    wait_idle();
    if_req = 1'b1; if_addr = 16'h0040;
    acks = 0; c1 = -1; c2 = -1; dacks = 0; g1 = 16'h0; g2 = 16'h0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (d_ack) dacks++;
      if (if_ack) begin
        acks++;
        if (acks == 1) begin c1 = n; g1 = if_rdata; if_addr = 16'h0043; end
        else if (acks == 2) begin c2 = n; g2 = if_rdata; if_req = 1'b0; end
      end
    end
    if_req = 1'b0;
    checks++;
    if (acks != 2 || c1 != 3 || c2 != 7 || dacks != 0) begin
      errors++; $display("FAIL b2b_timing: acks %0d at %0d,%0d dacks %0d want 2 at 3,7 0", acks, c1, c2, dacks);
    end
    checks++;
    if (g1 !== ref_mem[8'h20] || g2 !== ref_mem[8'h21]) begin
      errors++; $display("FAIL b2b_data: %h %h want %h %h", g1, g2, ref_mem[8'h20], ref_mem[8'h21]);
    end
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    @(negedge clk);
    init_mem();
    test_reset();
    test_word_load();
    test_byte_load();
    test_store();
    test_arbitration();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory access controller sitting directly upstream of the 16-bit byte-addressed main memory.
- Arbitrates between an instruction-fetch port (word reads only) and a datapath data port (byte/word loads and stores).
- Sequences the memory strobes and turns byte stores into read-modify-write operations.
- Returns read data through a req/ack handshake.

Parameters:
- AW, 16, address width (byte address)
- DW, 16, data width (two byte lanes, little-endian)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  16  fetch byte address; bit0 ignored (word aligned)
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  16  fetched word; valid with if_ack, held until next if_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_byte  in  1  1 = byte access, 0 = word access
- d_addr  in  16  data byte address; word accesses ignore bit0
- d_wdata  in  16  store data; byte store uses [7:0]
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  16  load result; byte load zero-extended; held until next d_ack
- mem_write  out  1  memory strobe bit
- mem_read  out  1  memory strobe bit
- mem_address  out  16  memory address, bit0 always 0
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data; valid the cycle after a read strobe
- busy  out  1  high in every state except IDLE

Behaviour:
- Strobe encoding is the memory's fixed convention:
  - {mem_write,mem_read} = 2'b01 → write
  - 2'b10 → read
  - 2'b00 → idle; 2'b11 is never driven
- Byte lanes: byte at even address is in [7:0], odd byte is in [15:8].
- Reset (asynchronous, any state):
  - state = IDLE; all outputs 0; strobes 2'b00; if_rdata/d_rdata cleared.
  - An in-flight transaction is dropped: no ack, no write.
- FSM states: IDLE, RD, WAIT, WR, ACK.
- IDLE:
  - If any req is high at the clock edge, grant one requester and latch its address (bit0 cleared for mem_address, lane kept), we, byte and wdata.
  - Fixed priority: data port wins over fetch on simultaneous requests.
  - Next state: word store → WR; load, fetch or byte store → RD.
- RD: strobe 2'b10 for exactly one cycle → WAIT.
- WAIT:
  - Strobes 2'b00; capture mem_data_out into an internal word register.
  - Load/fetch → ACK.
  - Byte store: merge d_wdata[7:0] into the lane selected by addr[0], other lane unchanged → WR.
- WR: strobe 2'b01 for exactly one cycle; mem_data_in = wdata (word) or merged word (byte) → ACK.
- ACK:
  - Pulse the granted port's ack for one cycle.
  - Update rdata for loads/fetches:
    - Word → full word.
    - Byte → selected lane in [7:0], [15:8] = 0.
  - Next state IDLE.
- Latency, counted from the IDLE sampling edge (ack high in cycle N):
  - Load or fetch: N = 3.
  - Word store: N = 2.
  - Byte store: N = 4.
- Handshake:
  - Requester holds req and all request fields stable until ack.
  - Requester must drop req in the ack cycle or a new transaction starts at the next IDLE edge. Back-to-back is legal, with a 1-cycle IDLE gap.
  - The ungranted requester waits and is not acked.
- mem_address and mem_data_in hold their last value outside RD/WR.

Optional Feature:
MEM_ARB_RR_EN:
- Defined: round-robin arbitration. On simultaneous requests, the port not granted most recently wins. The last-grant flag resets to "fetch", so the first tie goes to the data port.
- Undefined: fixed priority, data over fetch.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst=0 mid-RD → strobes 2'b00 at once, no ack; after release, busy=0 and all outputs 0.
- Word load: memory word 0x2BCD at 0x0000; d_req, d_we=0, d_byte=0, d_addr=0x0001 → mem_address=0x0000, strobe 2'b10 for 1 cycle, d_ack in cycle 3, d_rdata=0x2BCD.
- Byte load: same memory, d_byte=1, d_addr=0x0001 → d_rdata=0x002B; d_addr=0x0000 → 0x00CD.
- Byte store RMW: memory 0x2BCD at 0x0000; d_we=1, d_byte=1, d_addr=0x0001, d_wdata=0x0077 → read then write of 0x77CD, d_ack in cycle 4; a following word load returns 0x77CD.
- Simultaneous if_req (0x0010) and d_req word store 0xBEEF at 0x0020:
  - Default build: data acked first at cycle 2; fetch acked later.
  - MEM_ARB_RR_EN build: repeat the tie and grants alternate.
- Back-to-back: fetch req held across its ack → second fetch starts after 1 IDLE cycle, if_ack pulses exactly once per transaction.
